// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping: button conditioning, 10 ms prescaler, 4-digit BCD count
// and the idle/run/pause/full sequencer feeding the display stage.
module stopwatch_core #(
    parameter int unsigned TICK_DIV        = 1_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       clear_btn,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic [3:0] s2,
    output logic [3:0] s3,
    output logic       running,
    output logic       full
);

    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;
    localparam logic [1:0] FULL   = 2'd3;

    logic [1:0] btn_raw;
    logic [1:0] press_c;

    assign btn_raw = {clear_btn, start_btn};

    // Per button: 2-flop synchronizer, stability counter, rising-edge press pulse.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            sync1_q, sync1_d;
        logic            sync2_q, sync2_d;
        logic            acc_q, acc_d;
        logic            acc_prev_q, acc_prev_d;
        logic [DB_W-1:0] cnt_q, cnt_d;

        always_comb begin
            sync1_d    = btn_raw[b];
            sync2_d    = sync1_q;
            acc_d      = acc_q;
            acc_prev_d = acc_q;
            cnt_d      = '0;
            if (sync2_q != acc_q) begin
                if (cnt_q == DB_MAX) begin
                    acc_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                acc_q      <= 1'b0;
                acc_prev_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                sync1_q    <= sync1_d;
                sync2_q    <= sync2_d;
                acc_q      <= acc_d;
                acc_prev_q <= acc_prev_d;
                cnt_q      <= cnt_d;
            end
        end

        assign press_c[b] = acc_q & ~acc_prev_q;
    end

    logic             start_press_c;
    logic             clear_press_c;
    logic [1:0]       state_q, state_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic [3:0][3:0]  dig_q, dig_d;
    logic [3:0][3:0]  dig_inc_c;
    logic             running_q, running_d;
    logic             full_q, full_d;
    logic             tick_c;
    logic             last_c;

    assign start_press_c = press_c[0];
    assign clear_press_c = press_c[1];
    assign tick_c        = (state_q == RUN) && (ps_q == PS_MAX);
    assign last_c        = (dig_q == 16'h9998);

    // BCD ripple increment with same-cycle carry across all four digits.
    always_comb begin
        logic carry;
        carry     = 1'b1;
        dig_inc_c = dig_q;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (dig_q[i] == 4'd9) begin
                    dig_inc_c[i] = 4'd0;
                end else begin
                    dig_inc_c[i] = dig_q[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        dig_d   = dig_q;
        case (state_q)
            IDLE: begin
                if (clear_press_c) begin
                    ps_d  = '0;
                    dig_d = '0;
                end else if (start_press_c) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ps_d = tick_c ? '0 : ps_q + PS_W'(1);
                if (tick_c) begin
                    dig_d = dig_inc_c;
                end
                // Reaching 99.99 takes priority over a coincident start press.
                if (tick_c && last_c) begin
                    state_d = FULL;
                end else if (start_press_c) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (clear_press_c) begin
                    state_d = IDLE;
                    ps_d    = '0;
                    dig_d   = '0;
                end else if (start_press_c) begin
                    state_d = RUN;
                end
            end
            FULL: begin
                if (clear_press_c) begin
                    state_d = IDLE;
                    ps_d    = '0;
                    dig_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        running_d = (state_d == RUN);
        full_d    = (state_d == FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ps_q      <= '0;
            dig_q     <= '0;
            running_q <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ps_q      <= ps_d;
            dig_q     <= dig_d;
            running_q <= running_d;
            full_q    <= full_d;
        end
    end

    assign s0      = dig_q[0];
    assign s1      = dig_q[1];
    assign s2      = dig_q[2];
    assign s3      = dig_q[3];
    assign running = running_q;
    assign full    = full_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: vector table, directed corner sequences and a
// random-button run checked every cycle against a count/phase reference model.
module tb_stopwatch_core;

    localparam int unsigned TD = 4;
    localparam int unsigned DB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start_btn = 1'b0, clear_btn = 1'b0;
    logic [3:0] s0, s1, s2, s3;
    logic       running, full;
    logic       reset_f = 1'b1, start_f = 1'b0, clear_f = 1'b0;
    logic [3:0] f_s0, f_s1, f_s2, f_s3;
    logic       f_running, f_full;

    stopwatch_core #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .clear_btn(clear_btn),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3), .running(running), .full(full));

    stopwatch_core #(.TICK_DIV(1), .DEBOUNCE_CYCLES(DB)) dut_f (
        .clk(clk), .reset(reset_f), .start_btn(start_f), .clear_btn(clear_f),
        .s0(f_s0), .s1(f_s1), .s2(f_s2), .s3(f_s3), .running(f_running), .full(f_full));

    always #5 clk = ~clk;

    wire [17:0] obs   = {s3, s2, s1, s0, running, full};
    wire [17:0] obs_f = {f_s3, f_s2, f_s1, f_s0, f_running, f_full};

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] expv(input int cnt, input bit r, input bit f);
        return {4'(cnt / 1000 % 10), 4'(cnt / 100 % 10), 4'(cnt / 10 % 10), 4'(cnt % 10), r, f};
    endfunction

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    // Reference model: count in hundredths, prescaler phase as an integer, and
    // a button accepted once its last DB+1 raw samples (seen 2 edges late) all differ.
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_FULL} mstate_t;
    mstate_t m_state = M_IDLE;
    int      m_count = 0;
    int      m_ps = 0;
    bit      m_acc [2];
    bit      m_press [2];
    bit      m_hist [2][DB+3];

    initial begin : model_p
        bit tick;
        bit all;
        bit raw [2];
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_state = M_IDLE;
                m_count = 0;
                m_ps    = 0;
                for (int b = 0; b < 2; b++) begin
                    m_acc[b]   = 1'b0;
                    m_press[b] = 1'b0;
                    for (int j = 0; j < int'(DB) + 3; j++) m_hist[b][j] = 1'b0;
                end
            end else begin
                tick = (m_state == M_RUN) && (m_ps == int'(TD) - 1);
                case (m_state)
                    M_IDLE: begin
                        if (m_press[1]) begin m_count = 0; m_ps = 0; end
                        else if (m_press[0]) m_state = M_RUN;
                    end
                    M_RUN: begin
                        if (tick) begin m_count++; m_ps = 0; end
                        else m_ps++;
                        if (tick && m_count == 9999) m_state = M_FULL;
                        else if (m_press[0]) m_state = M_PAUSED;
                    end
                    M_PAUSED: begin
                        if (m_press[1]) begin m_state = M_IDLE; m_count = 0; m_ps = 0; end
                        else if (m_press[0]) m_state = M_RUN;
                    end
                    default: begin
                        if (m_press[1]) begin m_state = M_IDLE; m_count = 0; m_ps = 0; end
                    end
                endcase
                raw[0] = start_btn;
                raw[1] = clear_btn;
                for (int b = 0; b < 2; b++) begin
                    for (int j = int'(DB) + 2; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
                    m_hist[b][0] = raw[b];
                    all = 1'b1;
                    for (int j = 2; j <= int'(DB) + 2; j++)
                        if (m_hist[b][j] == m_acc[b]) all = 1'b0;
                    m_press[b] = all && !m_acc[b];
                    if (all) m_acc[b] = !m_acc[b];
                end
            end
        end
    end

    initial begin : cmp_p
        forever begin
            @(negedge clk);
            if (chk_en) chk("model", obs, expv(m_count, m_state == M_RUN, m_state == M_FULL));
        end
    end

    initial begin : watchdog_p
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          st;
        bit          cl;
        int          n;
        logic [15:0] bcd;
        bit          run;
        bit          fl;
    } vec_t;

    vec_t vecs [13];

    initial begin : main_p
        int e;
        int n0;
        bit found;

        vecs[0]  = '{1'b1, 1'b0, 5,  16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1,  16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1,  16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 3,  16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1,  16'h0001, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32, 16'h0009, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4,  16'h0010, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 6,  16'h0011, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 10, 16'h0014, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 7,  16'h0015, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 20, 16'h0015, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 7,  16'h0000, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 10, 16'h0000, 1'b0, 1'b0};

        #2;
        reset   = 1'b0;
        reset_f = 1'b0;
        #1;
        chk("reset_state", obs, 18'h0);
        chk("reset_state_f", obs_f, 18'h0);
        repeat (3) @(negedge clk);
        reset   = 1'b1;
        reset_f = 1'b1;
        chk_en  = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            start_btn = vecs[i].st;
            clear_btn = vecs[i].cl;
            repeat (vecs[i].n) @(negedge clk);
            chk($sformatf("vec%0d", i), obs, {vecs[i].bcd, vecs[i].run, vecs[i].fl});
        end

        // Bouncy start: 1 for 2 cycles, 0 for 2, then held high.
        e = edge_cnt;
        start_btn = 1'b1;
        repeat (2) @(negedge clk);
        start_btn = 1'b0;
        repeat (2) @(negedge clk);
        start_btn = 1'b1;
        wait_edge(e + 10);
        chk("bounce_not_yet", obs, expv(0, 1'b0, 1'b0));
        wait_edge(e + 11);
        chk("bounce_one_press", obs, expv(0, 1'b1, 1'b0));
        e = e + 11;
        wait_edge(e + 1);
        start_btn = 1'b0;
        wait_edge(e + 15);
        chk("release_no_effect", obs, expv(3, 1'b1, 1'b0));

        // Pause at 00.05 with prescaler phase 2, hold, resume.
        start_btn = 1'b1;
        wait_edge(e + 20);
        start_btn = 1'b0;
        wait_edge(e + 21);
        chk("pre_pause", obs, expv(5, 1'b1, 1'b0));
        wait_edge(e + 22);
        chk("paused", obs, expv(5, 1'b0, 1'b0));
        wait_edge(e + 122);
        chk("paused_hold", obs, expv(5, 1'b0, 1'b0));
        start_btn = 1'b1;
        wait_edge(e + 127);
        start_btn = 1'b0;
        wait_edge(e + 128);
        chk("resume_not_yet", obs, expv(5, 1'b0, 1'b0));
        wait_edge(e + 130);
        chk("resume_run", obs, expv(5, 1'b1, 1'b0));
        wait_edge(e + 131);
        chk("resume_phase", obs, expv(6, 1'b1, 1'b0));

        // Random button activity, checked every cycle by the model.
        for (int i = 0; i < 500; i++) begin
            start_btn = ($urandom_range(0, 3) == 0);
            clear_btn = ($urandom_range(0, 5) == 0);
            repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        start_btn = 1'b0;
        clear_btn = 1'b0;

        // Fast instance: async reset mid-count at 12.34.
        start_f = 1'b1;
        repeat (5) @(negedge clk);
        start_f = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (obs_f[17:2] == 16'h1234) found = 1'b1;
        end
        chk("reach_1234", 18'(found), 18'd1);
        #2;
        reset_f = 1'b0;
        #1;
        chk("async_reset_f", obs_f, 18'h0);
        @(negedge clk);
        reset_f = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_after_reset_f", obs_f, 18'h0);

        // Fast instance: run to 99.99 and saturate in FULL.
        n0 = edge_cnt;
        start_f = 1'b1;
        repeat (5) @(negedge clk);
        start_f = 1'b0;
        e = n0 + 7;
        wait_edge(e + 9995);
        chk("f_9995", obs_f, expv(9995, 1'b1, 1'b0));
        wait_edge(e + 9998);
        chk("f_9998", obs_f, expv(9998, 1'b1, 1'b0));
        wait_edge(e + 9999);
        chk("f_full", obs_f, expv(9999, 1'b0, 1'b1));
        start_f = 1'b1;
        repeat (5) @(negedge clk);
        start_f = 1'b0;
        repeat (20) @(negedge clk);
        chk("f_full_start", obs_f, expv(9999, 1'b0, 1'b1));
        clear_f = 1'b1;
        repeat (5) @(negedge clk);
        clear_f = 1'b0;
        repeat (10) @(negedge clk);
        chk("f_full_clear", obs_f, expv(0, 1'b0, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Timekeeping stage of the stopwatch. It conditions the raw start/stop and clear buttons, runs a 10 ms prescaler and a 4-digit BCD count (00.00–99.99 s), and sequences idle/run/pause/full. Its s0..s3 digit outputs feed the display-multiplex/driver stage directly; the decimal point and digit scanning live downstream.

## Interface
- TICK_DIV, 1_000_000: clk cycles per 0.01 s count (100 MHz → 10 ms).
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level.
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- start_btn  in  1  raw start/stop button, active-high, asynchronous to clk.
- clear_btn  in  1  raw clear button, active-high, asynchronous to clk.
- s0  out  4  BCD hundredths of a second (least significant digit).
- s1  out  4  BCD tenths of a second.
- s2  out  4  BCD units of seconds.
- s3  out  4  BCD tens of seconds (most significant digit).
- running  out  1  high while the state is RUN.
- full  out  1  high while the state is FULL (99.99 reached).

## Operation
- Button path, per button, identical:
  - 2-flop synchronizer.
  - Debounce counter: the accepted level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - The rising edge of the accepted level gives a 1-cycle press pulse. Release generates nothing.
- State machine:
  - States: IDLE, RUN, PAUSED, FULL.
  - start press: IDLE→RUN, RUN→PAUSED, PAUSED→RUN, FULL→FULL.
  - clear press in PAUSED or FULL: →IDLE, digits and prescaler zeroed.
  - clear press in IDLE: digits and prescaler rezeroed (no visible change).
  - clear press in RUN: ignored.
  - start and clear pressed in the same cycle: in RUN, start wins (→PAUSED) and clear is dropped. In PAUSED or FULL, clear wins (→IDLE). In IDLE, clear wins (stay IDLE).
- Prescaler:
  - Range 0..TICK_DIV-1. Advances only in RUN.
  - Holds its value in PAUSED, so phase is kept across pause/resume.
  - Zeroed by reset and clear.
  - tick = (state==RUN) && (prescaler==TICK_DIV-1). On tick the prescaler returns to 0.
- Counter:
  - Each digit is 0..9 BCD, never A–F.
  - On tick, s0 increments. A digit wraps 9→0 and carries into the next digit in the same cycle.
  - The tick that moves the count from 99.98 to 99.99 also moves the state to FULL. No wrap to 00.00 ever occurs.
- Tick and start press in the same cycle (RUN): the increment is applied and the state becomes PAUSED at the same edge.

## Timing
- Reset (async assert, any time including mid-count): s0..s3=0, running=0, full=0, state IDLE. Prescaler, debounce counters, synchronizers and accepted levels are all 0. A button held across reset release is accepted as a new press after the debounce time.
- Button latency: raw input goes high and stays stable before edge k. The accepted level goes high at edge k+2+DEBOUNCE_CYCLES. The press pulse is high during the following cycle, and the state/outputs change at edge k+3+DEBOUNCE_CYCLES.
- Count latency: the first tick comes TICK_DIV cycles after entering RUN from IDLE. s0 updates at the edge ending the tick cycle. After that, one increment every TICK_DIV cycles while in RUN.
- running and full are registered state decodes. They change at the same edge as the state.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
(TICK_DIV=4, DEBOUNCE_CYCLES=3 unless stated.)
- Reset mid-count at 12.34 → all digits 0, running=0, full=0 immediately, without waiting for a clk edge. After release, the counter stays at 00.00 until a start press.
- Clean start press from IDLE → running=1 exactly 6 edges after raw rise. s0=1 after 4 further edges. 00.10 after 40 cycles in RUN, with a 00.09→00.10 carry.
- Bouncy start: toggle raw input 1-0-1 with 2-cycle gaps, then hold high → exactly one press, accepted 3 stable cycles after the last bounce. Release → no state change.
- Pause at 00.05 with prescaler=2, wait 100 cycles → digits hold. Resume → next increment after exactly 2 cycles of RUN.
- Run from 99.95 (reached with TICK_DIV=1) → stops at 99.99 with full=1, running=0. Further start presses leave it at 99.99. A clear press gives 00.00, full=0, IDLE.
- Simultaneous start+clear: in RUN → PAUSED with digits kept. In PAUSED → IDLE with 00.00. A clear during RUN alone → ignored, count continues.
